uart_rx: RTL and testbench
==========================

# uart_rx

Serial receiver for the host link. It samples the asynchronous `rx` line and recovers 8N1 UART frames (1 start, 8 data LSB-first, 1 stop, no parity). Each good byte is presented on `dout` with a one-cycle `rx_done` strobe, which feeds the 128-bit block assembler directly downstream. Framing errors and false starts are filtered out here, so the downstream stage only ever sees complete bytes.

## Interface
- `CLKS_PER_BIT`, default 868: system clocks per bit period (100 MHz / 115200). Minimum 8.
- `clk` input 1: system clock; all logic is on the rising edge.
- `reset` input 1: asynchronous, active-low reset.
- `rx` input 1: raw serial line; idles high; asynchronous to `clk`.
- `dout` output 8: last correctly received byte; held until the next good frame.
- `rx_done` output 1: one-cycle pulse; `dout` is valid in the same cycle.
- `frame_err` output 1: one-cycle pulse when a sampled stop bit is 0.
- `busy` output 1: high in every state except IDLE.

## Operation
- `rx` passes through a 2-flop synchronizer, giving `rx_s`. All decisions use `rx_s` only.
- Bit-period counter `ctr` is `$clog2(CLKS_PER_BIT)` bits wide. Bit index `bit_idx` is 3 bits. The shift register is 8 bits.
- States: IDLE, START, DATA, STOP, DONE, BREAK.
  - **IDLE:** on `rx_s`=0, clear `ctr` and go to START.
  - **START:** count to `CLKS_PER_BIT/2 - 1` (mid-bit).
    - If `rx_s`=1 there, it is a false start: return to IDLE with no pulse.
    - Otherwise clear `ctr` and `bit_idx`, then go to DATA.
  - **DATA:** every `CLKS_PER_BIT` clocks, sample `rx_s` into the shift register, shifting right so the first bit lands at bit 0 (LSB first). After sample `bit_idx`=7, go to STOP.
  - **STOP:** after `CLKS_PER_BIT` clocks, sample `rx_s`.
    - If 1, load `dout` from the shift register and go to DONE.
    - If 0, pulse `frame_err`, leave `dout` unchanged and go to BREAK.
  - **DONE:** assert `rx_done` for this one cycle, then go to IDLE.
  - **BREAK:** wait until `rx_s`=1, then go to IDLE. A held-low line, or break condition, produces exactly one `frame_err` and no `rx_done`.
- Reset values: `dout`=8'h00, `rx_done`=0, `frame_err`=0, `busy`=0, state IDLE. The synchronizer flops reset to 1 (line idle), so deasserting reset while `rx` is high causes no false start.
- Reset asserted mid-frame abandons the frame immediately, with no pulses. Reception resumes at the next falling edge after release.
- `rx_done` and `frame_err` are never high in the same cycle.

## Timing
- From the first `rx`=0 at the pin to `rx_done` is 2 (synchronizer) + `CLKS_PER_BIT/2` + 9·`CLKS_PER_BIT` + 1 clocks, ±1 for edge alignment.
- Back-to-back frames: after DONE the block is in IDLE. The stop bit's second half, about `CLKS_PER_BIT/2` clocks, is available to catch the next start edge. No byte is lost at full line rate.
- The downstream consumer must sample `dout` in the `rx_done` cycle or before the next `rx_done`. The minimum spacing between pulses is 10·`CLKS_PER_BIT` − `CLKS_PER_BIT/2` clocks.
- There is no backpressure; the consumer is assumed always ready.

## Structure
- Shared package `uart_pkg` holds:
  - the state encoding (`IDLE`=0 … `BREAK`=5, 3 bits);
  - the default `CLKS_PER_BIT`;
  - the frame constants (`DATA_BITS`=8, `STOP_BITS`=1), shared with the future transmitter.
- One sub-module, `sync_2ff`: a parameterised-reset-value 2-flop synchronizer, also reused by the transmitter side.
- The FSM, counters and shift register stay in `uart_rx`.

## Test plan
All scenarios use `CLKS_PER_BIT`=16.
- **Single byte:** send 8'hA5, then idle. Expect `dout`=8'hA5, exactly one `rx_done` about 155 clocks after the start edge, and `frame_err` never high.
- **Glitch:** drive `rx` low for 5 clocks, then high. Expect no `rx_done`, no `frame_err`, and `busy` back to 0 within 10 clocks.
- **Bad stop bit:** send 8'h3C with stop bit 0, then hold low for 40 clocks, then go high. Expect one `frame_err`, no `rx_done`, `dout` unchanged, and the next valid byte 8'h55 received correctly.
- **Back-to-back stream:** send bytes 8'h00…8'h0F with no idle gap. Expect 16 `rx_done` pulses with matching `dout` values in order.
- **Reset mid-frame:** assert `reset` during data bit 4 of 8'hFF. Expect all outputs at reset values immediately. After release, a following 8'h81 is received correctly.
- **Baud tolerance:** send 8'hC3 with the bit period stretched to 17 clocks, then compressed to 15. Expect `dout`=8'hC3 both times.

Source files
------------

// File: rtl/uart_pkg.sv
// Purpose: shared UART definitions for the receiver and the future transmitter.
// Latency: none (types and constants only).
// Backpressure: none.
// Contents: FSM state encoding, default bit period, frame shape constants.
package uart_pkg;

  // Receiver FSM states; the numeric encoding is fixed so both sides agree.
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    STOP  = 3'd3,
    DONE  = 3'd4,
    BREAK = 3'd5
  } uart_state_e;

  // 100 MHz core clock / 115200 baud.
  localparam int CLKS_PER_BIT_DEFAULT = 868;

  // 8N1 frame shape.
  localparam int DATA_BITS = 8;
  localparam int STOP_BITS = 1;

endpackage

// File: rtl/uart_rx_if.sv
// Purpose: groups the serial line and received-byte outputs of the UART receiver.
// Latency: none (wires only).
// Backpressure: none; the byte consumer is always ready.
// Modports: master = receiver (reads rx, drives dout/rx_done/frame_err/busy),
//           slave  = line driver / byte consumer.
interface uart_rx_if;
  import uart_pkg::*;

  logic                 rx;
  logic [DATA_BITS-1:0] dout;
  logic                 rx_done;
  logic                 frame_err;
  logic                 busy;

  modport master (
    input  rx,
    output dout,
    output rx_done,
    output frame_err,
    output busy
  );

  modport slave (
    output rx,
    input  dout,
    input  rx_done,
    input  frame_err,
    input  busy
  );

endinterface

// File: rtl/uart_rx_sync_2ff.sv
// Purpose: two-flop synchronizer for a single asynchronous bit, reset value selectable.
// Latency: 2 clk from d to q.
// Backpressure: none.
// Ports: clk, reset (async active-low), d (async input), q (synchronized output).
module sync_2ff #(
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic meta_d, meta_q;
  logic sync_d, sync_q;

  always_comb begin
    meta_d = d;
    sync_d = meta_q;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      meta_q <= RESET_VAL;
      sync_q <= RESET_VAL;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/uart_rx.sv
// Purpose: 8N1 UART receiver; filters false starts and bad stop bits, emits good bytes only.
// Latency: start edge at pin to rx_done = 2 + CLKS_PER_BIT/2 + 9*CLKS_PER_BIT + 1 clk (+-1).
// Backpressure: none; dout must be taken in the rx_done cycle or before the next one.
// Ports: clk, reset (async active-low), bus (uart_rx_if.master: rx in; dout, rx_done,
//        frame_err, busy out).
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  uart_rx_if.master   bus
);

  localparam int CTR_W = $clog2(CLKS_PER_BIT);
  localparam logic [CTR_W-1:0] HALF_LAST = CTR_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CTR_W-1:0] BIT_LAST  = CTR_W'(CLKS_PER_BIT - 1);
  localparam logic [2:0]       IDX_LAST  = 3'(DATA_BITS - 1);

  logic rx_s;

  // Reset to 1 so a released reset with an idle line never looks like a start edge.
  sync_2ff #(.RESET_VAL(1'b1)) u_sync (
    .clk   (clk),
    .reset (reset),
    .d     (bus.rx),
    .q     (rx_s)
  );

  uart_state_e          state_d, state_q;
  logic [CTR_W-1:0]     ctr_d, ctr_q;
  logic [2:0]           bit_idx_d, bit_idx_q;
  logic [DATA_BITS-1:0] shift_d, shift_q;
  logic [DATA_BITS-1:0] dout_d, dout_q;
  logic                 frame_err_d, frame_err_q;

  always_comb begin
    state_d     = state_q;
    ctr_d       = ctr_q;
    bit_idx_d   = bit_idx_q;
    shift_d     = shift_q;
    dout_d      = dout_q;
    frame_err_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (!rx_s) begin
          ctr_d   = '0;
          state_d = START;
        end
      end

      START: begin
        // Re-check the line at mid start bit; a high here was only a glitch.
        if (ctr_q == HALF_LAST) begin
          if (rx_s) begin
            state_d = IDLE;
          end else begin
            ctr_d     = '0;
            bit_idx_d = '0;
            state_d   = DATA;
          end
        end else begin
          ctr_d = ctr_q + 1'b1;
        end
      end

      DATA: begin
        // Counter was aligned to mid-bit in START, so each wrap lands mid-bit.
        if (ctr_q == BIT_LAST) begin
          ctr_d     = '0;
          shift_d   = {rx_s, shift_q[DATA_BITS-1:1]};
          bit_idx_d = bit_idx_q + 3'd1;
          if (bit_idx_q == IDX_LAST) begin
            state_d = STOP;
          end
        end else begin
          ctr_d = ctr_q + 1'b1;
        end
      end

      STOP: begin
        if (ctr_q == BIT_LAST) begin
          ctr_d = '0;
          if (rx_s) begin
            dout_d  = shift_q;
            state_d = DONE;
          end else begin
            frame_err_d = 1'b1;
            state_d     = BREAK;
          end
        end else begin
          ctr_d = ctr_q + 1'b1;
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      BREAK: begin
        // A held-low line would otherwise retrigger START forever.
        if (rx_s) begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      ctr_q       <= '0;
      bit_idx_q   <= '0;
      shift_q     <= '0;
      dout_q      <= '0;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      ctr_q       <= ctr_d;
      bit_idx_q   <= bit_idx_d;
      shift_q     <= shift_d;
      dout_q      <= dout_d;
      frame_err_q <= frame_err_d;
    end
  end

  // rx_done lives only in DONE and frame_err only in the first BREAK cycle,
  // so the two can never coincide.
  assign bus.dout      = dout_q;
  assign bus.rx_done   = (state_q == DONE);
  assign bus.frame_err = frame_err_q;
  assign bus.busy      = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Purpose: self-checking bench for uart_rx with directed frames and an event-queue model.
// Latency: nominal frames are expected to complete 155 clk after the start edge (+-1).
// Backpressure: none; every pulse is consumed in the cycle it appears.
module tb_uart_rx;
  import uart_pkg::*;

  localparam int CPB = 16;
  localparam int LAT = 2 + CPB / 2 + 9 * CPB + 1;

  typedef struct {
    logic        is_err;
    logic [7:0]  data;
    longint      t_exp;   // -1 when timing is not checked
  } ev_t;

  logic   clk   = 1'b0;
  logic   reset = 1'b0;
  longint cyc   = 0;
  int     total = 0;
  int     bad   = 0;
  int     done_cnt = 0;
  int     err_cnt  = 0;
  ev_t    exp_q[$];
  logic [7:0] mdl_dout = 8'h00;

  uart_rx_if u_if ();

  uart_rx #(.CLKS_PER_BIT(CPB)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (u_if.master)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Model: each frame the bench sends pushes the one event the line protocol
  // dictates (good byte or framing error); every pulse must match the queue head.
  always @(negedge clk) begin
    ev_t ev;
    if (!reset) begin
      mdl_dout = 8'h00;
    end else begin
      chk("done_err_exclusive", {31'd0, u_if.rx_done & u_if.frame_err}, 32'd0);
      if (u_if.rx_done || u_if.frame_err) begin
        if (u_if.rx_done) done_cnt++;
        if (u_if.frame_err) err_cnt++;
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL unexpected_pulse: got rx_done=%0b frame_err=%0b, expected none (cycle %0d)",
                   u_if.rx_done, u_if.frame_err, cyc);
        end else begin
          ev = exp_q.pop_front();
          if (u_if.frame_err !== ev.is_err) begin
            bad++;
            $display("FAIL pulse_kind: got frame_err=%0b, expected frame_err=%0b (cycle %0d)",
                     u_if.frame_err, ev.is_err, cyc);
          end
          if (!ev.is_err) mdl_dout = ev.data;
          if (ev.t_exp >= 0) begin
            total++;
            if (cyc < ev.t_exp - 1 || cyc > ev.t_exp + 1) begin
              bad++;
              $display("FAIL pulse_latency: got cycle %0d, expected %0d +-1", cyc, ev.t_exp);
            end
          end
        end
      end
      chk("dout_model", {24'd0, u_if.dout}, {24'd0, mdl_dout});
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] b, input int p, input logic stop_val);
    ev_t e;
    e.is_err = ~stop_val;
    e.data   = b;
    e.t_exp  = (p == CPB) ? cyc + LAT : -1;
    exp_q.push_back(e);
    u_if.rx = 1'b0;
    repeat (p) step();
    for (int i = 0; i < 8; i++) begin
      u_if.rx = b[i];
      repeat (p) step();
    end
    u_if.rx = stop_val;
    repeat (p) step();
  endtask

  task automatic drain();
    int n = 0;
    u_if.rx = 1'b1;
    while (exp_q.size() != 0 && n < 400) begin
      step();
      n++;
    end
    chk("pending_events", exp_q.size(), 0);
  endtask

  initial begin
    int d0, e0;
    u_if.rx = 1'b1;
    reset   = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_dout", {24'd0, u_if.dout}, 32'h00);
    chk("reset_rx_done", {31'd0, u_if.rx_done}, 32'd0);
    chk("reset_frame_err", {31'd0, u_if.frame_err}, 32'd0);
    chk("reset_busy", {31'd0, u_if.busy}, 32'd0);
    reset = 1'b1;
    repeat (5) step();
    chk("idle_after_release_busy", {31'd0, u_if.busy}, 32'd0);

    // Single byte
    d0 = done_cnt; e0 = err_cnt;
    send_frame(8'hA5, CPB, 1'b1);
    repeat (20) step();
    drain();
    chk("single_dout", {24'd0, u_if.dout}, 32'hA5);
    chk("single_done_count", done_cnt - d0, 1);
    chk("single_err_count", err_cnt - e0, 0);

    // Glitch
    d0 = done_cnt; e0 = err_cnt;
    u_if.rx = 1'b0;
    repeat (5) step();
    chk("glitch_busy_high", {31'd0, u_if.busy}, 32'd1);
    u_if.rx = 1'b1;
    repeat (10) step();
    chk("glitch_busy_low", {31'd0, u_if.busy}, 32'd0);
    chk("glitch_done_count", done_cnt - d0, 0);
    chk("glitch_err_count", err_cnt - e0, 0);

    // Bad stop bit, then a held-low break
    d0 = done_cnt; e0 = err_cnt;
    send_frame(8'h3C, CPB, 1'b0);
    u_if.rx = 1'b0;
    repeat (40) step();
    u_if.rx = 1'b1;
    repeat (20) step();
    chk("badstop_err_count", err_cnt - e0, 1);
    chk("badstop_done_count", done_cnt - d0, 0);
    chk("badstop_dout_held", {24'd0, u_if.dout}, 32'hA5);
    chk("badstop_busy", {31'd0, u_if.busy}, 32'd0);
    send_frame(8'h55, CPB, 1'b1);
    drain();
    chk("after_break_dout", {24'd0, u_if.dout}, 32'h55);

    // Back-to-back stream
    d0 = done_cnt;
    for (int i = 0; i < 16; i++) send_frame(8'(i), CPB, 1'b1);
    drain();
    chk("stream_done_count", done_cnt - d0, 16);
    chk("stream_last_dout", {24'd0, u_if.dout}, 32'h0F);

    // Reset during data bit 4 of 8'hFF
    u_if.rx = 1'b0;
    repeat (CPB) step();
    u_if.rx = 1'b1;
    repeat (4 * CPB + CPB / 2) step();
    chk("midframe_busy", {31'd0, u_if.busy}, 32'd1);
    reset = 1'b0;
    #1;
    chk("midreset_dout", {24'd0, u_if.dout}, 32'h00);
    chk("midreset_rx_done", {31'd0, u_if.rx_done}, 32'd0);
    chk("midreset_frame_err", {31'd0, u_if.frame_err}, 32'd0);
    chk("midreset_busy", {31'd0, u_if.busy}, 32'd0);
    repeat (3) step();
    reset = 1'b1;
    repeat (5) step();
    d0 = done_cnt; e0 = err_cnt;
    send_frame(8'h81, CPB, 1'b1);
    drain();
    chk("after_reset_dout", {24'd0, u_if.dout}, 32'h81);
    chk("after_reset_counts", (done_cnt - d0) * 16 + (err_cnt - e0), 16);

    // Baud tolerance: slow then fast sender
    d0 = done_cnt;
    send_frame(8'hC3, CPB + 1, 1'b1);
    drain();
    repeat (10) step();
    chk("slow_baud_dout", {24'd0, u_if.dout}, 32'hC3);
    send_frame(8'h5A, CPB, 1'b1);
    drain();
    send_frame(8'hC3, CPB - 1, 1'b1);
    drain();
    repeat (10) step();
    chk("fast_baud_dout", {24'd0, u_if.dout}, 32'hC3);
    chk("baud_done_count", done_cnt - d0, 3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
